// File: rtl/mem_pkg.sv
// Shared types and constants for the memory-stage access controller.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } mem_state_t;

    localparam logic [1:0] FAULT_NONE     = 2'b00;
    localparam logic [1:0] FAULT_MISALIGN = 2'b01;
    localparam logic [1:0] FAULT_TIMEOUT  = 2'b10;

    localparam int BYTE_LANES = 8;

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane steering: byte enables, replicated store data and
// zero-extended extraction of the addressed load byte.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic                    byte_op,
    input  logic [2:0]              lane,
    input  logic [63:0]             wr_data,
    input  logic [63:0]             rd_data,
    output logic [BYTE_LANES-1:0]   be,
    output logic [63:0]             wdata,
    output logic [63:0]             rd_aligned
);

    logic [7:0] rd_byte;

    assign rd_byte = rd_data[{lane, 3'b000} +: 8];

    // Byte stores replicate the byte across all lanes; the enable picks the lane.
    assign be         = byte_op ? (BYTE_LANES'(1) << lane) : {BYTE_LANES{1'b1}};
    assign wdata      = byte_op ? {BYTE_LANES{wr_data[7:0]}} : wr_data;
    assign rd_aligned = byte_op ? {56'b0, rd_byte} : rd_data;

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage controller: turns loads/stores into a request/ready access to a
// variable-latency data memory and stalls the upstream pipeline meanwhile.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = $clog2(TIMEOUT + 1)
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead_mem,
    input  logic        MemWrite_mem,
    input  logic        byte_op_mem,
    input  logic [63:0] alu_result_mem,
    input  logic [63:0] wr_data_mem,
    output logic [63:0] dm_read_data_mem,
    output logic        mem_stall,
    output logic        mem_fault,
    output logic [1:0]  fault_code,
    output logic        dm_req,
    output logic        dm_we,
    output logic [63:0] dm_addr,
    output logic [7:0]  dm_be,
    output logic [63:0] dm_wdata,
    input  logic        dm_ready,
    input  logic [63:0] dm_rdata
);

    mem_state_t       state;
    logic [CNT_W-1:0] cnt;

    logic        op_valid;
    logic        misaligned;
    logic        is_store;
    logic [7:0]  lane_be;
    logic [63:0] lane_wdata;
    logic [63:0] lane_rdata;

    assign op_valid   = MemRead_mem | MemWrite_mem;
    assign misaligned = ~byte_op_mem & (alu_result_mem[2:0] != 3'b000);
    assign is_store   = MemWrite_mem & ~MemRead_mem;

    mem_lane_align u_lane_align (
        .byte_op    (byte_op_mem),
        .lane       (alu_result_mem[2:0]),
        .wr_data    (wr_data_mem),
        .rd_data    (dm_rdata),
        .be         (lane_be),
        .wdata      (lane_wdata),
        .rd_aligned (lane_rdata)
    );

    // Handshake: dm_req rises on entering ACCESS and, together with dm_we,
    // dm_addr, dm_be and dm_wdata, stays stable until the cycle in which
    // dm_ready pulses (transfer happens there) or the timeout aborts it.
    assign dm_req   = (state == ACCESS);
    assign dm_we    = dm_req & is_store;
    assign dm_addr  = dm_req ? {alu_result_mem[63:3], 3'b000} : 64'd0;
    assign dm_be    = dm_req ? lane_be : 8'd0;
    assign dm_wdata = dm_req ? lane_wdata : 64'd0;

    // Reset releases the pipeline at once rather than waiting for IDLE decode.
    assign mem_stall = ~reset & ((state == ACCESS) | ((state == IDLE) & op_valid));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            cnt              <= '0;
            dm_read_data_mem <= 64'd0;
            mem_fault        <= 1'b0;
            fault_code       <= FAULT_NONE;
        end else begin
            case (state)
                IDLE: begin
                    mem_fault  <= 1'b0;
                    fault_code <= FAULT_NONE;
                    if (op_valid) begin
                        if (misaligned) begin
                            state            <= DONE;
                            mem_fault        <= 1'b1;
                            fault_code       <= FAULT_MISALIGN;
                            dm_read_data_mem <= 64'd0;
                        end else begin
                            cnt   <= '0;
                            state <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    cnt <= cnt + CNT_W'(1);
                    // A completion in the last allowed cycle beats the timeout.
                    if (dm_ready) begin
                        state            <= DONE;
                        dm_read_data_mem <= is_store ? 64'd0 : lane_rdata;
                    end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        state            <= DONE;
                        mem_fault        <= 1'b1;
                        fault_code       <= FAULT_TIMEOUT;
                        dm_read_data_mem <= 64'd0;
                    end
                end
                DONE: begin
                    state      <= IDLE;
                    mem_fault  <= 1'b0;
                    fault_code <= FAULT_NONE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: table-driven transactions plus
// hand-written reset-during-access sequence.
module tb_mem_access_unit;

    logic        clk;
    logic        reset;
    logic        MemRead_mem;
    logic        MemWrite_mem;
    logic        byte_op_mem;
    logic [63:0] alu_result_mem;
    logic [63:0] wr_data_mem;
    logic [63:0] dm_read_data_mem;
    logic        mem_stall;
    logic        mem_fault;
    logic [1:0]  fault_code;
    logic        dm_req;
    logic        dm_we;
    logic [63:0] dm_addr;
    logic [7:0]  dm_be;
    logic [63:0] dm_wdata;
    logic        dm_ready;
    logic [63:0] dm_rdata;

    int checks;
    int errors;

    mem_access_unit #(.TIMEOUT(16)) dut (
        .clk              (clk),
        .reset            (reset),
        .MemRead_mem      (MemRead_mem),
        .MemWrite_mem     (MemWrite_mem),
        .byte_op_mem      (byte_op_mem),
        .alu_result_mem   (alu_result_mem),
        .wr_data_mem      (wr_data_mem),
        .dm_read_data_mem (dm_read_data_mem),
        .mem_stall        (mem_stall),
        .mem_fault        (mem_fault),
        .fault_code       (fault_code),
        .dm_req           (dm_req),
        .dm_we            (dm_we),
        .dm_addr          (dm_addr),
        .dm_be            (dm_be),
        .dm_wdata         (dm_wdata),
        .dm_ready         (dm_ready),
        .dm_rdata         (dm_rdata)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic        bt;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] rdata;
        int          wait_n;
        int          exp_stall;
        int          exp_reqs;
        logic        exp_we;
        logic [7:0]  exp_be;
        logic [63:0] exp_wdata;
        logic [63:0] exp_data;
        logic        exp_fault;
        logic [1:0]  exp_code;
    } vec_t;

    localparam int NV = 12;
    vec_t vecs[NV];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drop_op();
        MemRead_mem    = 1'b0;
        MemWrite_mem   = 1'b0;
        byte_op_mem    = 1'b0;
        alu_result_mem = 64'd0;
        wr_data_mem    = 64'd0;
        dm_ready       = 1'b0;
        dm_rdata       = 64'd0;
    endtask

    // driver + checker for one transaction from IDLE through DONE
    task automatic run_op(input int idx, input vec_t v);
        int  stalls;
        int  reqs;
        bit  done;
        string tag;
        stalls = 0;
        reqs   = 0;
        done   = 1'b0;
        tag    = $sformatf("v%0d", idx);
        @(negedge clk);
        MemRead_mem    = v.rd;
        MemWrite_mem   = v.wr;
        byte_op_mem    = v.bt;
        alu_result_mem = v.addr;
        wr_data_mem    = v.wdata;
        dm_rdata       = v.rdata;
        dm_ready       = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            #1;
            if (dm_req) begin
                check({tag, "_addr"},  dm_addr,  v.addr & ~64'h7);
                check({tag, "_be"},    {56'd0, dm_be}, {56'd0, v.exp_be});
                check({tag, "_wdata"}, dm_wdata, v.exp_wdata);
                check({tag, "_we"},    {63'd0, dm_we}, {63'd0, v.exp_we});
                dm_ready = (reqs == v.wait_n);
                reqs++;
            end
            if (mem_stall) begin
                stalls++;
            end else begin
                done = 1'b1;
                check({tag, "_stall_cycles"}, 64'(stalls), 64'(v.exp_stall));
                check({tag, "_req_cycles"},   64'(reqs),   64'(v.exp_reqs));
                check({tag, "_data"},  dm_read_data_mem, v.exp_data);
                check({tag, "_fault"}, {63'd0, mem_fault},  {63'd0, v.exp_fault});
                check({tag, "_code"},  {62'd0, fault_code}, {62'd0, v.exp_code});
                check({tag, "_done_req"}, {63'd0, dm_req}, 64'd0);
            end
            if (!done) begin
                @(negedge clk);
                dm_ready = 1'b0;
            end
        end
        if (!done) check({tag, "_completion_bound"}, 64'd0, 64'd1);
        @(negedge clk);
        drop_op();
        #1;
        check({tag, "_idle_stall"}, {63'd0, mem_stall}, 64'd0);
        check({tag, "_idle_fault"}, {61'd0, mem_fault, fault_code}, 64'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;

        //            rd   wr   bt   addr                   wdata                  rdata                  wait stall reqs we   be     exp_wdata              exp_data               flt  code
        vecs[0]  = '{1'b1,1'b0,1'b0,64'h40,               64'h0,                 64'h1122334455667788,  0,   2,   1,   1'b0,8'hFF,64'h0,                 64'h1122334455667788,  1'b0,2'b00};
        vecs[1]  = '{1'b1,1'b0,1'b1,64'h45,               64'h0,                 64'h1122334455667788,  0,   2,   1,   1'b0,8'h20,64'h0,                 64'h33,                1'b0,2'b00};
        vecs[2]  = '{1'b0,1'b1,1'b1,64'h13,               64'hAB,                64'hFFFF_FFFF_FFFF_FFFF,3,   5,   4,   1'b1,8'h08,64'hABABABABABABABAB,  64'h0,                 1'b0,2'b00};
        vecs[3]  = '{1'b1,1'b0,1'b1,64'h7,                64'h0,                 64'hA1B2C3D4E5F60718,  2,   4,   3,   1'b0,8'h80,64'h0,                 64'hA1,                1'b0,2'b00};
        vecs[4]  = '{1'b1,1'b0,1'b0,64'h44,               64'h0,                 64'h1122334455667788,  0,   1,   0,   1'b0,8'h00,64'h0,                 64'h0,                 1'b1,2'b01};
        vecs[5]  = '{1'b0,1'b1,1'b0,64'h1000,             64'h0123456789ABCDEF,  64'h5A5A5A5A5A5A5A5A,  1,   3,   2,   1'b1,8'hFF,64'h0123456789ABCDEF,  64'h0,                 1'b0,2'b00};
        vecs[6]  = '{1'b1,1'b0,1'b1,64'h8,                64'h77,                64'hA1B2C3D4E5F60718,  0,   2,   1,   1'b0,8'h01,64'h7777777777777777,  64'h18,                1'b0,2'b00};
        vecs[7]  = '{1'b1,1'b1,1'b0,64'h20,               64'h5555555555555555,  64'hCAFEF00D12345678,  0,   2,   1,   1'b0,8'hFF,64'h5555555555555555,  64'hCAFEF00D12345678,  1'b0,2'b00};
        vecs[8]  = '{1'b0,1'b1,1'b0,64'h21,               64'h1,                 64'h0,                 0,   1,   0,   1'b0,8'h00,64'h0,                 64'h0,                 1'b1,2'b01};
        vecs[9]  = '{1'b1,1'b0,1'b0,64'hFFFFFFFFFFFFFFF8, 64'h0,                 64'h8000000000000001,  0,   2,   1,   1'b0,8'hFF,64'h0,                 64'h8000000000000001,  1'b0,2'b00};
        vecs[10] = '{1'b1,1'b0,1'b0,64'h80,               64'h0,                 64'h1111111111111111,  255, 17,  16,  1'b0,8'hFF,64'h0,                 64'h0,                 1'b1,2'b10};
        vecs[11] = '{1'b1,1'b0,1'b0,64'h88,               64'h0,                 64'h2222222222222222,  15,  17,  16,  1'b0,8'hFF,64'h0,                 64'h2222222222222222,  1'b0,2'b00};

        reset = 1'b1;
        drop_op();
        #1;
        check("rst_data",  dm_read_data_mem, 64'd0);
        check("rst_stall", {63'd0, mem_stall}, 64'd0);
        check("rst_req",   {63'd0, dm_req}, 64'd0);
        check("rst_fault", {61'd0, mem_fault, fault_code}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < NV; i++) run_op(i, vecs[i]);

        // reset asserted mid-cycle during the 2nd ACCESS cycle
        @(negedge clk);
        MemRead_mem    = 1'b1;
        alu_result_mem = 64'h48;
        dm_rdata       = 64'hDEADBEEFDEADBEEF;
        #1;
        check("rr_idle_stall", {63'd0, mem_stall}, 64'd1);
        @(negedge clk);
        #1;
        check("rr_access1_req", {63'd0, dm_req}, 64'd1);
        @(negedge clk);
        #1;
        check("rr_access2_req", {63'd0, dm_req}, 64'd1);
        reset = 1'b1;
        #1;
        check("rr_req",   {63'd0, dm_req}, 64'd0);
        check("rr_stall", {63'd0, mem_stall}, 64'd0);
        check("rr_data",  dm_read_data_mem, 64'd0);
        check("rr_fault", {61'd0, mem_fault, fault_code}, 64'd0);
        check("rr_dm_bus", {dm_we, dm_be, dm_addr[54:0]} | 64'(dm_wdata != 64'd0), 64'd0);
        @(negedge clk);
        drop_op();
        reset = 1'b0;
        #1;
        check("rr_post_stall", {63'd0, mem_stall}, 64'd0);

        // controller must be back in IDLE and fully usable
        run_op(99, vecs[1]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Memory-stage access controller between the EX/MEM pipeline register and reg_mem_wb. It converts LDUR/LDURB/STUR/STURB requests into a request/ready handshake to a variable-latency data memory. It freezes the upstream pipeline with mem_stall until the access completes. It presents load data, aligned and zero-extended, to reg_mem_wb on dm_read_data_mem.

Parameters:
TIMEOUT, 16, maximum cycles in ACCESS before the access is aborted with a fault.
CNT_W, $clog2(TIMEOUT+1), width of the timeout counter.

Ports:
clk  input  1  pipeline clock; all state updates on the rising edge
reset  input  1  asynchronous, active-high reset
MemRead_mem  input  1  load in MEM stage
MemWrite_mem  input  1  store in MEM stage
byte_op_mem  input  1  1 = byte access (LDURB/STURB), 0 = doubleword access
alu_result_mem  input  64  effective byte address
wr_data_mem  input  64  store data; byte stores use bits [7:0]
dm_read_data_mem  output  64  registered load result, to reg_mem_wb
mem_stall  output  1  freeze PC, IF/ID, ID/EX and EX/MEM; insert bubble
mem_fault  output  1  registered; completed access faulted
fault_code  output  2  00 none, 01 misaligned, 10 timeout
dm_req  output  1  memory request, held until dm_ready
dm_we  output  1  1 = write
dm_addr  output  64  doubleword-aligned address, {alu_result_mem[63:3],3'b0}
dm_be  output  8  byte enables
dm_wdata  output  64  lane-positioned write data
dm_ready  input  1  one-cycle completion pulse; dm_rdata valid in the same cycle
dm_rdata  input  64  read data for the full doubleword

Behaviour:
- States: IDLE, ACCESS, DONE. Reset (asynchronous) forces IDLE, counter 0, dm_read_data_mem 0, mem_fault 0, fault_code 00. Reset mid-ACCESS abandons the transaction and deasserts dm_req immediately.
- op_valid = MemRead_mem | MemWrite_mem.
- If both MemRead_mem and MemWrite_mem are asserted, the access is a read (dm_we=0).
- IDLE, op_valid=0: mem_stall 0, dm_req 0.
- IDLE, op_valid=1 and the access is a misaligned doubleword (byte_op_mem=0 and alu_result_mem[2:0]≠0):
  - mem_stall 1; no request issued.
  - Next state DONE, with fault_code 01, mem_fault 1, dm_read_data_mem 0.
- IDLE, op_valid=1 and the access is otherwise legal: mem_stall 1; counter cleared; next state ACCESS.
- ACCESS:
  - dm_req 1. dm_we, dm_addr, dm_be and dm_wdata are combinational from the frozen EX/MEM inputs and stay stable while dm_req is high.
  - mem_stall 1 throughout ACCESS.
  - Counter increments each cycle.
- ACCESS, dm_ready=1: capture read data. A byte load captures {56'b0, dm_rdata[8*a+7 -: 8]} with a = alu_result_mem[2:0]. A doubleword load captures dm_rdata. A store captures 0. Next state DONE, fault 00.
- ACCESS timeout: when the counter reaches TIMEOUT with dm_ready=0, drop dm_req, set fault_code 10 and mem_fault 1, load data 0, go to DONE. If dm_ready=1 arrives in the timeout cycle, the completion wins.
- DONE:
  - mem_stall 0, dm_req 0. reg_mem_wb samples dm_read_data_mem at the end of this cycle.
  - The still-present op is ignored.
  - Next state IDLE. mem_fault and fault_code clear on leaving DONE.
- Byte enables and write data:
  - Doubleword: dm_be=8'hFF, dm_wdata=wr_data_mem.
  - Byte: dm_be=8'b1<<a, dm_wdata={8{wr_data_mem[7:0]}}.
  - Little-endian lane order throughout.
- Latency: a legal access with dm_ready in its first ACCESS cycle stalls 2 cycles (IDLE, ACCESS) and completes in DONE; each extra memory wait cycle adds one stall cycle. A misaligned access stalls 1 cycle.
- Back-to-back memory ops: each op passes through IDLE, so there is 1 non-stall cycle (DONE) between accesses.

Decomposition:
- mem_pkg holds:
  - the state enum (IDLE, ACCESS, DONE);
  - fault code constants FAULT_NONE, FAULT_MISALIGN, FAULT_TIMEOUT;
  - BYTE_LANES=8.
- One combinational sub-module, mem_lane_align, computes dm_be, dm_wdata and the extracted/zero-extended read data from byte_op_mem, alu_result_mem[2:0], wr_data_mem and dm_rdata.

Test Plan:
- LDUR at addr 0x40, dm_ready on the 1st ACCESS cycle, dm_rdata=0x1122334455667788 -> mem_stall high 2 cycles; DONE cycle shows dm_read_data_mem=0x1122334455667788 with mem_fault 0.
- LDURB at addr 0x45, same dm_rdata -> dm_addr=0x40; DONE shows dm_read_data_mem=0x0000000000000033.
- STURB at addr 0x13, wr_data=0xAB, memory waits 3 cycles -> dm_we=1, dm_be=8'h08, dm_wdata=0xABABABABABABABAB held stable; mem_stall high 5 cycles.
- LDUR at addr 0x44 -> no dm_req; 1 stall cycle; DONE shows mem_fault=1, fault_code=01, data 0.
- LDUR with dm_ready never asserted, TIMEOUT=16 -> dm_req drops after the 16th ACCESS cycle; DONE shows fault_code=10.
- Reset asserted in the 2nd ACCESS cycle -> dm_req and mem_stall go 0 without waiting for a clock edge; state IDLE; all outputs zero.
